// File: rtl/uart_rx_core.sv
// UART receiver: 16x-oversampled 8N1 deserialiser with a one-entry
// holding register, valid/ready output and framing/overrun pulses.
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic                 tick_i,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q, busy_d;
  logic                   rxs;
  logic                   load;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = rxd_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    load    = 1'b0;
    if (tick_i) begin
      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            tcnt_d  = '0;
          end
        end
        START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            // A start bit gone high by mid-bit is a glitch.
            state_d = rxs ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == B_LAST) begin
              state_d = STOP;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d = '0;
            if (rxs) begin
              state_d = IDLE;
              load    = 1'b1;
            end else begin
              ferr_d  = 1'b1;
              state_d = BRK;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        BRK: begin
          if (rxs) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (load) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '1;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;

endmodule
